ndata_stream_merger: RTL and testbench

Merges NUM_INPUTS ndata streams into one output stream using packet-aware round-robin arbitration behind a single full-throughput output register. It sits downstream of the NDataDuplicator fan-out and its per-branch processing stages. It recombines the branches into one stream, keeping each packet (beats up to and including `last`) contiguous. It also tags every output beat with the index of its source input.

---
 rtl/ndata_stream_merger.sv | 131 +++++++++++++
 tb/tb_ndata_stream_merger.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ndata_stream_merger.sv
// Packet-aware round-robin merge of NUM_INPUTS ndata streams into one registered
// output stream; every output beat carries the index of the input it came from.
module ndata_stream_merger #(
   parameter int unsigned NUM_INPUTS   = 2,
   parameter bit          LOCK_PACKET  = 1'b1,
   parameter int unsigned NUM_ELEMENTS = 4,
   parameter int unsigned DATA_W       = 8,
   localparam int unsigned ID_W        = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
   localparam int unsigned BEAT_W      = NUM_ELEMENTS * DATA_W
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_INPUTS*BEAT_W-1:0]     i_in_data,
   input  logic [NUM_INPUTS*NUM_ELEMENTS-1:0] i_in_keep,
   input  logic [NUM_INPUTS-1:0]            i_in_last,
   input  logic [NUM_INPUTS-1:0]            i_in_valid,
   output logic [NUM_INPUTS-1:0]            o_in_ready,
   output logic [BEAT_W-1:0]                o_out_data,
   output logic [NUM_ELEMENTS-1:0]          o_out_keep,
   output logic                             o_out_last,
   output logic                             o_out_valid,
   input  logic                             i_out_ready,
   output logic [ID_W-1:0]                  o_out_id
);

   typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

   state_t                  r_state, w_state_nxt;
   logic [ID_W-1:0]         r_ptr, r_lock_idx;
   logic [ID_W-1:0]         w_gnt, w_gnt_inc, w_scan;
   logic                    w_gnt_vld, w_can_load, w_accept;
   logic [BEAT_W-1:0]       w_in_data;
   logic [NUM_ELEMENTS-1:0] w_in_keep;
   logic                    w_in_last, w_in_valid;

   logic [BEAT_W-1:0]       r_out_data;
   logic [NUM_ELEMENTS-1:0] r_out_keep;
   logic                    r_out_last, r_out_valid;
   logic [ID_W-1:0]         r_out_id;

   // Holding reset keeps every ready low, not just the registered state.
   assign w_can_load = rst_n && (!r_out_valid || i_out_ready);

   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt     = '0;
      w_scan    = '0;
      if (r_state == ST_LOCKED) begin
         w_gnt_vld = 1'b1;
         w_gnt     = r_lock_idx;
      end else begin
         for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
            w_scan = ID_W'((32'(r_ptr) + k) % NUM_INPUTS);
            if (!w_gnt_vld && i_in_valid[w_scan]) begin
               w_gnt_vld = 1'b1;
               w_gnt     = w_scan;
            end
         end
      end
   end

   assign w_gnt_inc = (w_gnt == ID_W'(NUM_INPUTS - 1)) ? '0 : w_gnt + 1'b1;

   always_comb begin
      w_in_data  = '0;
      w_in_keep  = '0;
      w_in_last  = 1'b0;
      w_in_valid = 1'b0;
      o_in_ready = '0;
      for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
         if (w_gnt == ID_W'(i)) begin
            w_in_data     = i_in_data[i*BEAT_W +: BEAT_W];
            w_in_keep     = i_in_keep[i*NUM_ELEMENTS +: NUM_ELEMENTS];
            w_in_last     = i_in_last[i];
            w_in_valid    = i_in_valid[i];
            o_in_ready[i] = w_gnt_vld && w_can_load;
         end
      end
   end

   assign w_accept = w_gnt_vld && w_in_valid && w_can_load;

   always_comb begin
      w_state_nxt = r_state;
      if (LOCK_PACKET && w_accept) begin
         if (r_state == ST_IDLE && !w_in_last)
            w_state_nxt = ST_LOCKED;
         else if (r_state == ST_LOCKED && w_in_last)
            w_state_nxt = ST_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ptr       <= '0;
         r_lock_idx  <= '0;
         r_out_data  <= '0;
         r_out_keep  <= '0;
         r_out_last  <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_id    <= '0;
      end else if (w_accept) begin
         r_out_data  <= w_in_data;
         r_out_keep  <= w_in_keep;
         r_out_last  <= w_in_last;
         r_out_valid <= 1'b1;
         r_out_id    <= w_gnt;
         if (r_state == ST_IDLE && w_state_nxt == ST_LOCKED)
            r_lock_idx <= w_gnt;
         // While locked w_gnt equals r_lock_idx, so w_gnt_inc is lock_idx+1.
         if (w_in_last || !LOCK_PACKET)
            r_ptr <= w_gnt_inc;
      end else if (i_out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign o_out_data  = r_out_data;
   assign o_out_keep  = r_out_keep;
   assign o_out_last  = r_out_last;
   assign o_out_valid = r_out_valid;
   assign o_out_id    = r_out_id;

endmodule

// File: tb/tb_ndata_stream_merger.sv
// Bench for ndata_stream_merger: a packet-locked and a beat-interleaved instance,
// checked against a queue-based round-robin scheduling model.
module tb_ndata_stream_merger;
   localparam int N  = 4;
   localparam int NE = 2;
   localparam int DW = 8;
   localparam int BW = NE * DW;

   typedef struct packed {
      logic [1:0]    id;
      logic          last;
      logic [NE-1:0] keep;
      logic [BW-1:0] data;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [N*BW-1:0] in_data   [2];
   logic [N*NE-1:0] in_keep   [2];
   logic [N-1:0]    in_last   [2];
   logic [N-1:0]    in_valid  [2];
   logic [N-1:0]    in_ready  [2];
   logic [BW-1:0]   out_data  [2];
   logic [NE-1:0]   out_keep  [2];
   logic            out_last  [2];
   logic            out_valid [2];
   logic            out_ready [2];
   logic [1:0]      out_id    [2];

   int errors = 0;
   int checks = 0;
   beat_t src_q [N][$];
   beat_t exp_q [$];
   int    model_ptr [2];

   ndata_stream_merger #(.NUM_INPUTS(N), .LOCK_PACKET(1'b1), .NUM_ELEMENTS(NE), .DATA_W(DW)) u_lock (
      .clk(clk), .rst_n(rst_n),
      .i_in_data(in_data[0]), .i_in_keep(in_keep[0]), .i_in_last(in_last[0]),
      .i_in_valid(in_valid[0]), .o_in_ready(in_ready[0]),
      .o_out_data(out_data[0]), .o_out_keep(out_keep[0]), .o_out_last(out_last[0]),
      .o_out_valid(out_valid[0]), .i_out_ready(out_ready[0]), .o_out_id(out_id[0]));

   ndata_stream_merger #(.NUM_INPUTS(N), .LOCK_PACKET(1'b0), .NUM_ELEMENTS(NE), .DATA_W(DW)) u_nolock (
      .clk(clk), .rst_n(rst_n),
      .i_in_data(in_data[1]), .i_in_keep(in_keep[1]), .i_in_last(in_last[1]),
      .i_in_valid(in_valid[1]), .o_in_ready(in_ready[1]),
      .o_out_data(out_data[1]), .o_out_keep(out_keep[1]), .o_out_last(out_last[1]),
      .o_out_valid(out_valid[1]), .i_out_ready(out_ready[1]), .o_out_id(out_id[1]));

   function automatic beat_t mk(input bit last);
      beat_t b;
      b.data = BW'($urandom);
      b.keep = NE'($urandom_range(0, 3));
      b.last = last;
      b.id   = 2'd0;
      return b;
   endfunction

   function automatic beat_t with_id(input beat_t b, input int id);
      beat_t r = b;
      r.id = 2'(id);
      return r;
   endfunction

   function automatic beat_t out_beat(input int sel);
      beat_t b;
      b.data = out_data[sel];
      b.keep = out_keep[sel];
      b.last = out_last[sel];
      b.id   = out_id[sel];
      return b;
   endfunction

   function automatic bit any_src();
      bit r = 1'b0;
      for (int i = 0; i < N; i++) if (src_q[i].size() > 0) r = 1'b1;
      return r;
   endfunction

   task automatic drive(input int sel, input int i, input beat_t b, input bit v);
      in_data[sel][i*BW +: BW] = b.data;
      in_keep[sel][i*NE +: NE] = b.keep;
      in_last[sel][i]          = b.last;
      in_valid[sel][i]         = v;
   endtask

   task automatic add_pkt(input int i, input int len);
      for (int j = 0; j < len; j++) src_q[i].push_back(mk(j == len - 1));
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      for (int s = 0; s < 2; s++) begin
         in_valid[s]  = '0;
         out_ready[s] = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_ptr[0] = 0;
      model_ptr[1] = 0;
   endtask

   // Reference order: starting at the pointer, the first input with pending beats
   // sends a whole packet (locked) or one beat (unlocked); pointer moves past it.
   task automatic model_build(input int sel, input bit lock);
      beat_t mq [N][$];
      beat_t b;
      int p = model_ptr[sel];
      int g;
      for (int i = 0; i < N; i++) mq[i] = src_q[i];
      forever begin
         g = -1;
         for (int k = 0; k < N; k++)
            if (g < 0 && mq[(p + k) % N].size() > 0) g = (p + k) % N;
         if (g < 0) break;
         do begin
            b = mq[g].pop_front();
            exp_q.push_back(with_id(b, g));
         end while (lock && !b.last && mq[g].size() > 0);
         p = (g + 1) % N;
      end
      model_ptr[sel] = p;
   endtask

   task automatic run_stream(input int sel, input bit lock, input bit rand_ready,
                             input bit no_bubble, input string name);
      beat_t acc_b, prev_out;
      bit    have_acc = 1'b0, stalled = 1'b0, seen_out = 1'b0;
      int    cyc = 0, nacc, acc_i;
      exp_q.delete();
      model_build(sel, lock);
      while (exp_q.size() > 0 && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         for (int i = 0; i < N; i++)
            if (src_q[i].size() > 0) drive(sel, i, src_q[i][0], 1'b1);
            else drive(sel, i, '0, 1'b0);
         out_ready[sel] = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
         #1;
         if (have_acc) begin
            checks++;
            if (out_valid[sel] !== 1'b1 || out_beat(sel) !== acc_b) begin
               errors++;
               $display("FAIL %s latency: got v=%b %h want %h", name, out_valid[sel], out_beat(sel), acc_b);
            end
         end
         if (stalled) begin
            checks++;
            if (out_valid[sel] !== 1'b1 || out_beat(sel) !== prev_out) begin
               errors++;
               $display("FAIL %s hold: got v=%b %h want %h", name, out_valid[sel], out_beat(sel), prev_out);
            end
         end
         if (out_valid[sel] && !out_ready[sel]) begin
            checks++;
            if (in_ready[sel] !== 4'b0000) begin
               errors++;
               $display("FAIL %s stall_ready: got %b want 0000", name, in_ready[sel]);
            end
         end
         if (no_bubble && seen_out && any_src()) begin
            checks++;
            if (out_valid[sel] !== 1'b1) begin
               errors++;
               $display("FAIL %s bubble: got out_valid=%b want 1", name, out_valid[sel]);
            end
         end
         if (out_valid[sel] && out_ready[sel]) begin
            seen_out = 1'b1;
            checks++;
            if (out_beat(sel) !== exp_q[0]) begin
               errors++;
               $display("FAIL %s order: got %h want %h", name, out_beat(sel), exp_q[0]);
            end
            void'(exp_q.pop_front());
         end
         prev_out = out_beat(sel);
         stalled  = out_valid[sel] && !out_ready[sel];
         nacc = 0;
         acc_i = 0;
         for (int i = 0; i < N; i++)
            if (in_valid[sel][i] && in_ready[sel][i]) begin
               nacc++;
               acc_i = i;
            end
         checks++;
         if (nacc > 1) begin
            errors++;
            $display("FAIL %s single_grant: got %0d accepts want <=1", name, nacc);
         end
         have_acc = (nacc == 1);
         if (have_acc) acc_b = with_id(src_q[acc_i][0], acc_i);
         @(posedge clk);
         if (have_acc) void'(src_q[acc_i].pop_front());
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s timeout: got %0d beats left want 0", name, exp_q.size());
      end
      @(negedge clk);
      in_valid[sel]  = '0;
      out_ready[sel] = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      for (int s = 0; s < 2; s++) begin
         in_valid[s]  = 4'hF;
         out_ready[s] = 1'b1;
      end
      #1;
      for (int s = 0; s < 2; s++) begin
         checks++;
         if (in_ready[s] !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready[%0d]: got %b want 0000", s, in_ready[s]);
         end
      end
      @(posedge clk);
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         checks++;
         if (out_valid[s] !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid[%0d]: got %b want 0", s, out_valid[s]);
         end
         checks++;
         if (out_beat(s) !== '0) begin
            errors++;
            $display("FAIL reset_out[%0d]: got %h want 0", s, out_beat(s));
         end
         in_valid[s] = '0;
      end
      rst_n = 1'b1;
      model_ptr[0] = 0;
      model_ptr[1] = 0;
   endtask

   task automatic test_single_packet();
      apply_reset();
      add_pkt(1, 3);
      run_stream(0, 1'b1, 1'b0, 1'b1, "single_pkt");
      // Pointer now sits at 2, so one-beat packets from all inputs go 2,3,0,1.
      for (int i = 0; i < N; i++) add_pkt(i, 1);
      run_stream(0, 1'b1, 1'b0, 1'b1, "ptr_after_pkt");
   endtask

   task automatic test_round_robin();
      apply_reset();
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < N; i++) add_pkt(i, 2);
      run_stream(0, 1'b1, 1'b0, 1'b1, "round_robin");
   endtask

   task automatic test_locked_interleave();
      beat_t a0 = mk(1'b0), a1 = mk(1'b1), b0 = mk(1'b0), b1 = mk(1'b1);
      apply_reset();
      @(negedge clk); drive(0, 0, a0, 1'b1);
      #1; checks++;
      if (in_ready[0] !== 4'b0001) begin errors++; $display("FAIL lock_a0_ready: got %b want 0001", in_ready[0]); end
      @(posedge clk);
      @(negedge clk); drive(0, 0, a0, 1'b0); drive(0, 1, b0, 1'b1);
      #1; checks++;
      if (out_beat(0) !== with_id(a0, 0) || out_valid[0] !== 1'b1) begin errors++; $display("FAIL lock_out_a0: got %h want %h", out_beat(0), with_id(a0, 0)); end
      checks++;
      if (in_ready[0][1] !== 1'b0) begin errors++; $display("FAIL lock_in1_blocked1: got %b want 0", in_ready[0][1]); end
      @(posedge clk);
      @(negedge clk); drive(0, 0, a1, 1'b1);
      #1; checks++;
      if (in_ready[0] !== 4'b0001) begin errors++; $display("FAIL lock_in1_blocked2: got %b want 0001", in_ready[0]); end
      @(posedge clk);
      @(negedge clk); drive(0, 0, a1, 1'b0);
      #1; checks++;
      if (out_beat(0) !== with_id(a1, 0) || out_valid[0] !== 1'b1) begin errors++; $display("FAIL lock_out_a1: got %h want %h", out_beat(0), with_id(a1, 0)); end
      checks++;
      if (in_ready[0] !== 4'b0010) begin errors++; $display("FAIL lock_in1_grant: got %b want 0010", in_ready[0]); end
      @(posedge clk);
      @(negedge clk); drive(0, 1, b1, 1'b1);
      #1; checks++;
      if (out_beat(0) !== with_id(b0, 1) || out_valid[0] !== 1'b1) begin errors++; $display("FAIL lock_out_b0: got %h want %h", out_beat(0), with_id(b0, 1)); end
      @(posedge clk);
      @(negedge clk); drive(0, 1, b1, 1'b0);
      #1; checks++;
      if (out_beat(0) !== with_id(b1, 1) || out_valid[0] !== 1'b1) begin errors++; $display("FAIL lock_out_b1: got %h want %h", out_beat(0), with_id(b1, 1)); end
      @(posedge clk);
   endtask

   task automatic test_backpressure();
      beat_t x0 = mk(1'b0), x1 = mk(1'b1), y0 = mk(1'b1);
      apply_reset();
      @(negedge clk); drive(0, 2, x0, 1'b1);
      @(posedge clk);
      @(negedge clk); drive(0, 2, x1, 1'b1); drive(0, 3, y0, 1'b1); out_ready[0] = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1; checks++;
         if (out_valid[0] !== 1'b1 || out_beat(0) !== with_id(x0, 2)) begin errors++; $display("FAIL bp_hold c%0d: got %h want %h", c, out_beat(0), with_id(x0, 2)); end
         checks++;
         if (in_ready[0] !== 4'b0000) begin errors++; $display("FAIL bp_ready c%0d: got %b want 0000", c, in_ready[0]); end
         @(posedge clk);
         @(negedge clk);
      end
      out_ready[0] = 1'b1;
      #1; checks++;
      if (in_ready[0] !== 4'b0100) begin errors++; $display("FAIL bp_release_ready: got %b want 0100", in_ready[0]); end
      @(posedge clk);
      @(negedge clk); drive(0, 2, x1, 1'b0);
      #1; checks++;
      if (out_valid[0] !== 1'b1 || out_beat(0) !== with_id(x1, 2)) begin errors++; $display("FAIL bp_x1: got %h want %h", out_beat(0), with_id(x1, 2)); end
      checks++;
      if (in_ready[0] !== 4'b1000) begin errors++; $display("FAIL bp_y_ready: got %b want 1000", in_ready[0]); end
      @(posedge clk);
      @(negedge clk); drive(0, 3, y0, 1'b0);
      #1; checks++;
      if (out_valid[0] !== 1'b1 || out_beat(0) !== with_id(y0, 3)) begin errors++; $display("FAIL bp_y0: got %h want %h", out_beat(0), with_id(y0, 3)); end
      @(posedge clk);
      @(negedge clk);
      #1; checks++;
      if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL bp_nodup: got valid=%b want 0", out_valid[0]); end
   endtask

   task automatic test_nolock();
      apply_reset();
      add_pkt(0, 4);
      add_pkt(2, 4);
      run_stream(1, 1'b0, 1'b0, 1'b1, "nolock_alt");
   endtask

   task automatic test_reset_mid_packet();
      beat_t z0 = mk(1'b0), z1 = mk(1'b1), w0 = mk(1'b1);
      apply_reset();
      @(negedge clk); drive(0, 3, z0, 1'b1);
      @(posedge clk);
      @(negedge clk); drive(0, 3, z1, 1'b1);
      #1; checks++;
      if (out_valid[0] !== 1'b1 || out_id[0] !== 2'd3) begin errors++; $display("FAIL mid_pre: got v=%b id=%0d want v=1 id=3", out_valid[0], out_id[0]); end
      rst_n = 1'b0;
      out_ready[0] = 1'b0;
      #1; checks++;
      if (in_ready[0] !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready: got %b want 0000", in_ready[0]); end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid[0] !== 1'b0 || out_beat(0) !== '0) begin errors++; $display("FAIL mid_cleared: got v=%b %h want v=0 0", out_valid[0], out_beat(0)); end
      rst_n = 1'b1;
      out_ready[0] = 1'b1;
      drive(0, 0, w0, 1'b1);
      #1; checks++;
      if (in_ready[0] !== 4'b0001) begin errors++; $display("FAIL mid_regrant: got %b want 0001", in_ready[0]); end
      @(posedge clk);
      @(negedge clk); drive(0, 0, w0, 1'b0); drive(0, 3, z1, 1'b0);
      #1; checks++;
      if (out_valid[0] !== 1'b1 || out_beat(0) !== with_id(w0, 0)) begin errors++; $display("FAIL mid_w0: got %h want %h", out_beat(0), with_id(w0, 0)); end
      @(posedge clk);
      model_ptr[0] = 1;
      model_ptr[1] = 0;
   endtask

   task automatic test_random();
      apply_reset();
      for (int it = 0; it < 8; it++) begin
         for (int i = 0; i < N; i++)
            for (int p = $urandom_range(0, 3); p > 0; p--) add_pkt(i, $urandom_range(1, 4));
         run_stream(it % 2, (it % 2) == 0, 1'b1, 1'b0, "random");
      end
   endtask

   initial begin
      for (int s = 0; s < 2; s++) begin
         in_data[s]   = '0;
         in_keep[s]   = '0;
         in_last[s]   = '0;
         in_valid[s]  = '0;
         out_ready[s] = 1'b1;
      end
      test_reset();
      test_single_packet();
      test_round_robin();
      test_locked_interleave();
      test_backpressure();
      test_nolock();
      test_reset_mid_packet();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
